// File: rtl/serial_pkg.sv
// Shared types and helpers for the MSB-first operand serializer.
package serial_pkg;

  typedef enum logic {SER_IDLE, SER_SHIFT} ser_state_e;

  typedef enum logic [1:0] {CMP_LESS, CMP_EQ, CMP_GREATER} cmp_result_e;

  // Bit-counter width: $clog2(width), never below one bit.
  function automatic int unsigned cnt_width(input int unsigned width);
    return (width > 1) ? int'($clog2(width)) : 1;
  endfunction

endpackage

// File: rtl/serial_shift_reg_msb.sv
// Loadable left-shift register presenting its MSB; zeros fill from the right.
module serial_shift_reg_msb #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic             i_shift,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_msb
);

  logic [WIDTH-1:0] r_q;

  // Load has priority so a back-to-back frame replaces the draining one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
    end else if (i_load) begin
      r_q <= i_data;
    end else if (i_shift) begin
      r_q <= r_q << 1;
    end
  end

  assign o_msb = r_q[WIDTH-1];

endmodule

// File: rtl/serial_operand_serializer_msb_first.sv
// Two-operand parallel-to-serial transmitter, MSB first, with frame markers.
// Optional SERIALIZER_EXPECT_EN adds registered golden compare outputs.
module serial_operand_serializer_msb_first
  import serial_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             a,
  output logic             b,
  output logic             bit_valid,
  output logic             first,
  output logic             last
`ifdef SERIALIZER_EXPECT_EN
  ,
  output logic             exp_less,
  output logic             exp_eq,
  output logic             exp_greater
`endif
);

  localparam int unsigned CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic ONE_BIT = 1'(WIDTH == 1);

  ser_state_e    r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;
  logic          r_valid, r_first, r_last;
  logic          w_valid_nxt, w_first_nxt, w_last_nxt;
  logic          w_cnt_last, w_accept, w_shift;

  assign w_cnt_last = (r_cnt == CNT_LAST);
  assign w_cnt_inc  = r_cnt + CW'(1);
  assign in_ready   = (r_state == SER_IDLE) | ((r_state == SER_SHIFT) & w_cnt_last);
  assign w_accept   = in_valid & in_ready;

  // Next state, bit counter and frame flags for the following cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_valid_nxt = 1'b0;
    w_first_nxt = 1'b0;
    w_last_nxt  = 1'b0;
    w_shift     = 1'b0;
    case (r_state)
      SER_IDLE: begin
        if (w_accept) begin
          w_state_nxt = SER_SHIFT;
          w_cnt_nxt   = '0;
          w_valid_nxt = 1'b1;
          w_first_nxt = 1'b1;
          w_last_nxt  = ONE_BIT;
        end
      end
      SER_SHIFT: begin
        w_shift = 1'b1;
        if (w_accept) begin
          w_state_nxt = SER_SHIFT;
          w_cnt_nxt   = '0;
          w_valid_nxt = 1'b1;
          w_first_nxt = 1'b1;
          w_last_nxt  = ONE_BIT;
        end else if (w_cnt_last) begin
          w_state_nxt = SER_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt   = w_cnt_inc;
          w_valid_nxt = 1'b1;
          w_last_nxt  = (w_cnt_inc == CNT_LAST);
        end
      end
      default: begin
        w_state_nxt = SER_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // State, counter and registered frame flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= SER_IDLE;
      r_cnt   <= '0;
      r_valid <= 1'b0;
      r_first <= 1'b0;
      r_last  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_valid <= w_valid_nxt;
      r_first <= w_first_nxt;
      r_last  <= w_last_nxt;
    end
  end

  assign bit_valid = r_valid;
  assign first     = r_first;
  assign last      = r_last;

  serial_shift_reg_msb #(.WIDTH(WIDTH)) u_shift_a (
    .clk     (clk),
    .rst_n   (rst),
    .i_load  (w_accept),
    .i_shift (w_shift),
    .i_data  (in_a),
    .o_msb   (a)
  );

  serial_shift_reg_msb #(.WIDTH(WIDTH)) u_shift_b (
    .clk     (clk),
    .rst_n   (rst),
    .i_load  (w_accept),
    .i_shift (w_shift),
    .i_data  (in_b),
    .o_msb   (b)
  );

`ifdef SERIALIZER_EXPECT_EN
  cmp_result_e w_cmp;
  logic        r_exp_less, r_exp_eq, r_exp_greater;

  // Unsigned compare of the offered pair.
  always_comb begin
    w_cmp = CMP_EQ;
    if (in_a < in_b) begin
      w_cmp = CMP_LESS;
    end else if (in_a > in_b) begin
      w_cmp = CMP_GREATER;
    end
  end

  // Capture the compare result with the pair; held until the next accept.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_exp_less    <= 1'b0;
      r_exp_eq      <= 1'b0;
      r_exp_greater <= 1'b0;
    end else if (w_accept) begin
      r_exp_less    <= (w_cmp == CMP_LESS);
      r_exp_eq      <= (w_cmp == CMP_EQ);
      r_exp_greater <= (w_cmp == CMP_GREATER);
    end
  end

  assign exp_less    = r_exp_less;
  assign exp_eq      = r_exp_eq;
  assign exp_greater = r_exp_greater;
`endif

endmodule

// File: tb/tb_serial_operand_serializer_msb_first.sv
// Bench for serial_operand_serializer_msb_first: WIDTH=4 and WIDTH=1 instances
// checked cycle by cycle against a queue-of-pending-bits reference model.
module tb_serial_operand_serializer_msb_first;

  typedef struct packed {
    logic a;
    logic b;
    logic first;
    logic last;
  } bit_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic       in_valid4 = 1'b0;
  logic [3:0] in_a4 = '0, in_b4 = '0;
  logic       in_ready4, a4, b4, bv4, first4, last4;

  logic       in_valid1 = 1'b0;
  logic [0:0] in_a1 = '0, in_b1 = '0;
  logic       in_ready1, a1, b1, bv1, first1, last1;

`ifdef SERIALIZER_EXPECT_EN
  logic       lt4, eq4, gt4, lt1, eq1, gt1;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  bit_t       q4[$];
  bit_t       q1[$];
  logic [2:0] m_exp4 = '0;
  logic [2:0] m_exp1 = '0;

  always #5 clk = ~clk;

  serial_operand_serializer_msb_first #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
    .in_a(in_a4), .in_b(in_b4), .a(a4), .b(b4), .bit_valid(bv4),
    .first(first4), .last(last4)
`ifdef SERIALIZER_EXPECT_EN
    , .exp_less(lt4), .exp_eq(eq4), .exp_greater(gt4)
`endif
  );

  serial_operand_serializer_msb_first #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
    .in_a(in_a1), .in_b(in_b1), .a(a1), .b(b1), .bit_valid(bv1),
    .first(first1), .last(last1)
`ifdef SERIALIZER_EXPECT_EN
    , .exp_less(lt1), .exp_eq(eq1), .exp_greater(gt1)
`endif
  );

  task automatic check(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Expected {a,b,bit_valid,first,last} from the head of a pending-bit queue.
  function automatic logic [4:0] head_of(input bit_t hd, input int sz);
    if (sz == 0) return 5'b0;
    return {hd.a, hd.b, 1'b1, hd.first, hd.last};
  endfunction

  function automatic logic [2:0] cmp_of(input int unsigned x, input int unsigned y);
    return {x < y, x == y, x > y};
  endfunction

  task automatic check_all();
    bit_t h4, h1;
    h4 = (q4.size() > 0) ? q4[0] : '0;
    h1 = (q1.size() > 0) ? q1[0] : '0;
    check("w4_outputs", {a4, b4, bv4, first4, last4}, head_of(h4, q4.size()));
    check("w4_in_ready", 5'(in_ready4), 5'(q4.size() <= 1));
    check("w1_outputs", {a1, b1, bv1, first1, last1}, head_of(h1, q1.size()));
    check("w1_in_ready", 5'(in_ready1), 5'(q1.size() <= 1));
`ifdef SERIALIZER_EXPECT_EN
    check("w4_expect", 5'({lt4, eq4, gt4}), 5'(m_exp4));
    check("w1_expect", 5'({lt1, eq1, gt1}), 5'(m_exp1));
`endif
  endtask

  // One clock: drive inputs, check current outputs, advance the model at the edge.
  task automatic step(input logic v4, input logic [3:0] xa4, input logic [3:0] xb4,
                      input logic v1, input logic xa1, input logic xb1);
    logic acc4, acc1;
    in_valid4 = v4; in_a4 = xa4; in_b4 = xb4;
    in_valid1 = v1; in_a1 = xa1; in_b1 = xb1;
    check_all();
    acc4 = v4 && (q4.size() <= 1);
    acc1 = v1 && (q1.size() <= 1);
    @(posedge clk);
    if (q4.size() > 0) void'(q4.pop_front());
    if (q1.size() > 0) void'(q1.pop_front());
    if (acc4) begin
      for (int i = 3; i >= 0; i--) q4.push_back('{xa4[i], xb4[i], i == 3, i == 0});
      m_exp4 = cmp_of(int'(xa4), int'(xb4));
    end
    if (acc1) begin
      q1.push_back('{xa1, xb1, 1'b1, 1'b1});
      m_exp1 = cmp_of(int'(xa1), int'(xb1));
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
  endtask

  // Asynchronous reset applied between edges, checked before any edge arrives.
  task automatic apply_reset();
    in_valid4 = 1'b0;
    in_valid1 = 1'b0;
    #1 rst = 1'b0;
    #1;
    q4.delete();
    q1.delete();
    m_exp4 = '0;
    m_exp1 = '0;
    check_all();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Power-on reset.
    #12;
    check_all();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Basic frame 1101 / 1011.
    step(1'b1, 4'b1101, 4'b1011, 1'b0, 1'b0, 1'b0);
    idle(5);

    // Back-to-back frames with in_valid held high.
    step(1'b1, 4'b0110, 4'b0110, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 4'b1001, 4'b1110, 1'b0, 1'b0, 1'b0);
    idle(5);

    // Stall: pulse during bit 1 ignored, held pair taken on the last bit.
    step(1'b1, 4'b1101, 4'b1011, 1'b0, 1'b0, 1'b0);
    step(1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
    step(1'b1, 4'b0011, 4'b0101, 1'b0, 1'b0, 1'b0);
    step(1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
    step(1'b1, 4'b0011, 4'b0101, 1'b0, 1'b0, 1'b0);
    idle(5);

    // Reset mid-frame after two bits, then a fresh frame.
    step(1'b1, 4'b1101, 4'b1011, 1'b0, 1'b0, 1'b0);
    idle(2);
    apply_reset();
    step(1'b1, 4'b1010, 4'b0101, 1'b0, 1'b0, 1'b0);
    idle(5);

    // WIDTH=1: single-cycle frames, accepted every cycle.
    for (int i = 0; i < 4; i++) step(1'b0, 4'h0, 4'h0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 4'h0, 4'h0, 1'b1, 1'b1, 1'b1);
    idle(2);

    // Randomized traffic on both instances, with one reset in the middle.
    for (int i = 0; i < 400; i++) begin
      if (i == 200) apply_reset();
      step($urandom_range(0, 3) != 0, 4'($urandom), 4'($urandom),
           $urandom_range(0, 2) != 0, 1'($urandom), 1'($urandom));
    end
    idle(6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
